tone_detector: RTL and testbench
================================

TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter TARGET_PERIOD, default 227272, expected full period of a 440 Hz input in clk cycles.
REQ-003 Parameter TOLERANCE, default 2272, maximum accepted absolute deviation from TARGET_PERIOD in cycles.
REQ-004 Parameter CONFIRM_COUNT, default 4, consecutive in-tolerance periods required to declare a tone.
REQ-005 Parameter TIMEOUT_LIMIT, default 454544, cycles without a rising edge before the tone is declared lost.
REQ-006 clk  input  1  100 MHz system clock; the only clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 detect_en  input  1  synchronous enable; low holds the block in its cleared state.
REQ-009 audio_in  input  1  asynchronous square-wave tone input (e.g. comparator output at the PmodAMP-side header).
REQ-010 period_out  output  19  last measured period in clk cycles.
REQ-011 period_valid  output  1  one-cycle pulse when period_out updates.
REQ-012 tone_present  output  1  high while a 440 Hz tone within tolerance is locked.
REQ-013 timeout  output  1  high while no rising edge has been seen for TIMEOUT_LIMIT cycles.

Function
REQ-014 audio_in SHALL pass through a two-flop synchronizer, then a registered rising-edge detector; edge latency from audio_in to internal edge pulse is 3 clk cycles.
REQ-015 A 19-bit period counter SHALL increment every cycle and saturate at TIMEOUT_LIMIT; on an edge pulse it SHALL load 1.
REQ-016 FSM states SHALL be IDLE, MEASURE, LOCKED.
REQ-017 IDLE: counter held at 0; the first edge pulse moves to MEASURE without producing a period.
REQ-018 MEASURE/LOCKED: on each edge pulse, period_out SHALL take the counter value and period_valid SHALL pulse high for exactly one cycle on the following clock edge.
REQ-019 A period SHALL be a match when |period - TARGET_PERIOD| <= TOLERANCE, computed with no overflow at 19 bits (boundary values inclusive).
REQ-020 A 3-bit match counter SHALL increment on each matching period, clear on any mismatch, and saturate at CONFIRM_COUNT.
REQ-021 MEASURE -> LOCKED when the match counter reaches CONFIRM_COUNT; tone_present SHALL rise in the same cycle as the period_valid for that period.
REQ-022 LOCKED -> MEASURE on any mismatching period; tone_present and the match counter SHALL clear in that cycle.
REQ-023 In MEASURE or LOCKED, counter reaching TIMEOUT_LIMIT SHALL move to IDLE, assert timeout, clear tone_present and match counter; timeout SHALL clear on the next edge pulse.
REQ-024 Edge pulse and timeout in the same cycle: the edge SHALL win (period measured, no timeout).
REQ-025 detect_en low SHALL force IDLE, clear counters, tone_present, timeout and period_valid; period_out holds its value.

Reset
REQ-026 On rst high, state = IDLE, synchronizer flops = 0, counters = 0, period_out = 0, period_valid = 0, tone_present = 0, timeout = 0, asynchronously.
REQ-027 Reset asserted mid-measurement SHALL discard any partial period; no period_valid SHALL follow release until two edges have been seen.

Structure
REQ-028 Package tone_pkg SHALL hold the FSM state type, the default CLK_HZ/TARGET_PERIOD/TOLERANCE/TIMEOUT_LIMIT constants and the 19-bit period width constant.
REQ-029 Sub-module edge_sync SHALL contain the two-flop synchronizer and rising-edge detector (in: clk, rst, async_in; out: rise_pulse).

Verification
REQ-030 Ideal 440 Hz square wave (113636 high/113636 low), detect_en=1 -> period_out=227272 each period, tone_present high after the 5th rising edge.
REQ-031 Periods of 229544 and 225000 (within / at edge) -> both match; 229545 -> mismatch, tone_present drops in that period_valid cycle.
REQ-032 Locked tone, then audio_in held low -> timeout and tone_present=0 exactly TIMEOUT_LIMIT cycles after the last edge counter load.
REQ-033 500 Hz input (period 200000) -> period_out=200000, tone_present never asserts.
REQ-034 rst pulsed while LOCKED -> all outputs 0 immediately; relock requires 5 edges after release.
REQ-035 detect_en dropped for 10 cycles while LOCKED -> tone_present=0, period_out unchanged, relock after 5 further edges.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and constants for the 440 Hz tone detector.
// Period arithmetic is held to the 19-bit counter width.
package tone_pkg;

  localparam int unsigned PERIOD_W          = 19;
  localparam int unsigned MATCH_W           = 3;
  localparam int unsigned CLK_HZ_DEF        = 100_000_000;
  localparam int unsigned TARGET_PERIOD_DEF = 227_272;
  localparam int unsigned TOLERANCE_DEF     = 2_272;
  localparam int unsigned CONFIRM_COUNT_DEF = 4;
  localparam int unsigned TIMEOUT_LIMIT_DEF = 454_544;

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [MATCH_W-1:0]  match_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // |period - target| <= tol, subtracting the smaller from the larger so nothing wraps.
  function automatic logic period_match(period_t period, period_t target, period_t tol);
    period_t diff;
    diff = (period >= target) ? (period - target) : (target - period);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// An input rise appears on rise_pulse three clocks later, for one cycle.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the period of a synchronized square wave and declares a tone once
// CONFIRM_COUNT consecutive periods fall within tolerance of TARGET_PERIOD.
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ        = CLK_HZ_DEF,
  parameter int unsigned TARGET_PERIOD = TARGET_PERIOD_DEF,
  parameter int unsigned TOLERANCE     = TOLERANCE_DEF,
  parameter int unsigned CONFIRM_COUNT = CONFIRM_COUNT_DEF,
  parameter int unsigned TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                detect_en,
  input  logic                audio_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                tone_present,
  output logic                timeout
);

  localparam period_t TARGET_P  = PERIOD_W'(TARGET_PERIOD);
  localparam period_t TOL_P     = PERIOD_W'(TOLERANCE);
  localparam period_t LIMIT_P   = PERIOD_W'(TIMEOUT_LIMIT);
  localparam match_t  CONFIRM_M = MATCH_W'(CONFIRM_COUNT);

  if (CLK_HZ == 0 || CONFIRM_COUNT == 0 || CONFIRM_COUNT >= (32'd1 << MATCH_W) ||
      TIMEOUT_LIMIT == 0 || TIMEOUT_LIMIT >= (32'd1 << PERIOD_W) ||
      TARGET_PERIOD >= (32'd1 << PERIOD_W) || TOLERANCE >= (32'd1 << PERIOD_W)) begin : g_bad_params
    $error("tone_detector: parameter out of range");
  end

  logic    rise;
  state_e  state_q, state_d;
  period_t cnt_q, cnt_d;
  match_t  match_q, match_d;
  period_t period_q, period_d;
  logic    pvalid_q, pvalid_d;
  logic    tone_q, tone_d;
  logic    timeout_q, timeout_d;

  logic    is_match;
  match_t  match_inc;
  period_t cnt_inc;

  edge_sync u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (audio_in),
    .rise_pulse (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      match_q   <= '0;
      period_q  <= '0;
      pvalid_q  <= 1'b0;
      tone_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      period_q  <= period_d;
      pvalid_q  <= pvalid_d;
      tone_q    <= tone_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    period_d  = period_q;
    pvalid_d  = 1'b0;
    tone_d    = tone_q;
    timeout_d = timeout_q;

    is_match  = period_match(cnt_q, TARGET_P, TOL_P);
    match_inc = (match_q >= CONFIRM_M) ? CONFIRM_M : (match_q + 1'b1);
    cnt_inc   = (cnt_q >= LIMIT_P) ? LIMIT_P : (cnt_q + 1'b1);

    if (!detect_en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      match_d   = '0;
      tone_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          match_d = '0;
          tone_d  = 1'b0;
          // First edge only starts the period; there is nothing to measure yet.
          if (rise) begin
            state_d   = ST_MEASURE;
            cnt_d     = PERIOD_W'(1);
            timeout_d = 1'b0;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          // An edge arriving with the counter at the limit still counts as a period.
          if (rise) begin
            cnt_d     = PERIOD_W'(1);
            period_d  = cnt_q;
            pvalid_d  = 1'b1;
            timeout_d = 1'b0;
            if (is_match) begin
              match_d = match_inc;
              if (match_inc == CONFIRM_M) begin
                state_d = ST_LOCKED;
                tone_d  = 1'b1;
              end
            end else begin
              match_d = '0;
              tone_d  = 1'b0;
              state_d = ST_MEASURE;
            end
          end else if (cnt_q == LIMIT_P) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            match_d   = '0;
            tone_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = pvalid_q;
  assign tone_present = tone_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_tone_detector.sv
// Randomized bench for tone_detector with scaled-down period parameters,
// checked against a model built from the rise times the bench drives.
module tb_tone_detector;
  import tone_pkg::*;

  localparam int unsigned TGT  = 200;
  localparam int unsigned TOL  = 10;
  localparam int unsigned CONF = 4;
  localparam int unsigned TO   = 500;

  logic                clk = 1'b0;
  logic                rst;
  logic                detect_en;
  logic                audio_in;
  logic [PERIOD_W-1:0] period_out;
  logic                period_valid;
  logic                tone_present;
  logic                timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned period;
    bit          tone;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_armed;
  int unsigned m_last_rise;
  int unsigned m_run;
  int unsigned m_last_period;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_detector #(
    .CLK_HZ        (100_000_000),
    .TARGET_PERIOD (TGT),
    .TOLERANCE     (TOL),
    .CONFIRM_COUNT (CONF),
    .TIMEOUT_LIMIT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .detect_en    (detect_en),
    .audio_in     (audio_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .tone_present (tone_present),
    .timeout      (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_armed = 1'b0;
    m_run   = 0;
    exp_q.delete();
  endtask

  // A tone is present when the last CONF periods since arming all matched.
  task automatic model_rise();
    int unsigned per;
    int unsigned dev;
    exp_t        e;
    if (m_armed) begin
      per = cyc - m_last_rise;
      if (per > TO) begin
        m_run = 0;
      end else begin
        dev = (per > TGT) ? (per - TGT) : (TGT - per);
        if (dev <= TOL) m_run = (m_run < CONF) ? (m_run + 1) : CONF;
        else            m_run = 0;
        e.period = per;
        e.tone   = (m_run == CONF);
        exp_q.push_back(e);
        m_last_period = per;
      end
    end
    m_armed     = 1'b1;
    m_last_rise = cyc;
  endtask

  task automatic drive_period(input int unsigned p);
    int unsigned h;
    h = p / 2;
    @(negedge clk);
    audio_in = 1'b1;
    model_rise();
    repeat (h) @(negedge clk);
    audio_in = 1'b0;
    repeat (p - h - 1) @(negedge clk);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (!rst && period_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("pv_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("period_out", 32'(period_out), e.period);
        check_eq("tone_at_pv", 32'(tone_present), 32'(e.tone));
        check_eq("timeout_at_pv", 32'(timeout), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned p;
    int unsigned sel;
    int unsigned held;

    rst       = 1'b1;
    detect_en = 1'b0;
    audio_in  = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_period", 32'(period_out), 32'd0);
    check_eq("rst_pvalid", 32'(period_valid), 32'd0);
    check_eq("rst_tone", 32'(tone_present), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);

    @(negedge clk);
    rst       = 1'b0;
    detect_en = 1'b1;

    // Ideal tone: lock on the fifth rising edge.
    repeat (6) drive_period(TGT);
    check_eq("lock_ideal", 32'(tone_present), 32'd1);

    // Tolerance boundaries inclusive, one past drops the lock.
    drive_period(TGT + TOL);
    drive_period(TGT - TOL);
    drive_period(TGT + TOL + 1);
    drive_period(TGT);
    check_eq("tone_after_mismatch", 32'(tone_present), 32'd0);
    check_eq("last_period_oob", 32'(period_out), TGT + TOL + 1);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: p = TGT - TOL + $urandom_range(0, 2 * TOL);
        6:                p = TGT + TOL + 1 + $urandom_range(0, 20);
        7:                p = TGT - TOL - 1 - $urandom_range(0, 20);
        8:                p = ($urandom_range(0, 1) != 0) ? (TGT + TOL) : (TGT - TOL);
        default:          p = $urandom_range(20, TO + 50);
      endcase
      drive_period(p);
    end

    // Off-frequency tone never locks.
    repeat (8) drive_period(176);
    check_eq("offfreq_period", 32'(period_out), 32'd176);
    check_eq("offfreq_tone", 32'(tone_present), 32'd0);

    // Lock, then stop edges: timeout exactly TO cycles after the last load.
    repeat (6) drive_period(TGT);
    @(negedge clk);
    audio_in = 1'b1;
    model_rise();
    repeat (4) @(posedge clk);
    repeat (TO - 1) @(posedge clk);
    #1;
    check_eq("timeout_early", 32'(timeout), 32'd0);
    check_eq("tone_before_to", 32'(tone_present), 32'd1);
    @(posedge clk);
    #1;
    check_eq("timeout_set", 32'(timeout), 32'd1);
    check_eq("tone_at_to", 32'(tone_present), 32'd0);
    @(negedge clk);
    audio_in = 1'b0;
    held = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (timeout !== 1'b1) held++;
    end
    check_eq("timeout_held", held, 32'd0);
    drive_period(TGT);
    check_eq("timeout_cleared", 32'(timeout), 32'd0);
    repeat (5) drive_period(TGT);
    check_eq("relock_after_to", 32'(tone_present), 32'd1);

    // Period equal to the limit is measured; one longer times out.
    drive_period(TO);
    drive_period(TO + 1);
    drive_period(TGT);
    drive_period(TGT);
    check_eq("period_after_to_edge", 32'(period_out), TGT);
    repeat (4) drive_period(TGT);
    check_eq("lock_before_rst", 32'(tone_present), 32'd1);

    // Asynchronous reset while locked.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_period", 32'(period_out), 32'd0);
    check_eq("arst_pvalid", 32'(period_valid), 32'd0);
    check_eq("arst_tone", 32'(tone_present), 32'd0);
    check_eq("arst_timeout", 32'(timeout), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) drive_period(TGT);
    check_eq("no_lock_4_edges", 32'(tone_present), 32'd0);
    repeat (2) drive_period(TGT);
    check_eq("relock_after_rst", 32'(tone_present), 32'd1);

    // Enable dropped for ten cycles while locked.
    drive_period(TGT + 3);
    drive_period(TGT);
    @(negedge clk);
    detect_en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("dis_tone", 32'(tone_present), 32'd0);
    check_eq("dis_timeout", 32'(timeout), 32'd0);
    check_eq("dis_pvalid", 32'(period_valid), 32'd0);
    check_eq("dis_period_hold", 32'(period_out), m_last_period);
    repeat (9) @(posedge clk);
    #1;
    check_eq("dis_period_hold2", 32'(period_out), m_last_period);
    @(negedge clk);
    detect_en = 1'b1;
    model_clear();
    repeat (4) drive_period(TGT);
    check_eq("dis_no_lock_4", 32'(tone_present), 32'd0);
    repeat (2) drive_period(TGT);
    check_eq("relock_after_dis", 32'(tone_present), 32'd1);

    repeat (10) @(posedge clk);
    #1;
    check_eq("pv_pending", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
